// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter
module ps2_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    // One timer serves as the RTS hold counter and, afterwards, as the watchdog.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_ACK, S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [FILTER_LEN-1:0]   filt_q, filt_d;
    logic                    lvl_q, lvl_d;
    logic [8:0]              sh_q, sh_d;
    logic [3:0]              bcnt_q, bcnt_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic                    ok_q, ok_d;
    logic                    c_oe_q, c_oe_d;
    logic                    d_oe_q, d_oe_d;
    logic                    idle_q, idle_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    fall_edge;
    logic                    watch;
    logic                    timeout;

    // Open-drain drivers: only ever pull low or release.
    assign ps2c = c_oe_q ? 1'b0 : 1'bz;
    assign ps2d = d_oe_q ? 1'b0 : 1'bz;

    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

    // Glitch filter on the device clock; the filtered level only moves on a unanimous window.
    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], ps2c};
        lvl_d  = lvl_q;
        if (&filt_q) begin
            lvl_d = 1'b1;
        end else if (~|filt_q) begin
            lvl_d = 1'b0;
        end
        fall_edge = lvl_q & ~|filt_q;
    end

    // Next-state logic: frame sequencing plus the watchdog abort that overrides it.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        tmr_d   = tmr_q;
        ok_d    = ok_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        watch   = (state_q == S_START) || (state_q == S_DATA) ||
                  (state_q == S_ACK)   || (state_q == S_WAIT);
        timeout = watch && !fall_edge && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

        if (watch) begin
            tmr_d = fall_edge ? '0 : tmr_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (wr_ps2) begin
                    sh_d    = {~^din, din};
                    c_oe_d  = 1'b1;
                    tmr_d   = '0;
                    ok_d    = 1'b0;
                    state_d = S_RTS;
                end
            end
            S_RTS: begin
                if (tmr_q == TW'(RTS_CYCLES - 1)) begin
                    tmr_d   = '0;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_START: begin
                bcnt_d  = 4'd0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (fall_edge) begin
                    if (bcnt_q == 4'd9) begin
                        d_oe_d  = 1'b0;
                        state_d = S_ACK;
                    end else begin
                        d_oe_d = ~sh_q[0];
                        sh_d   = {1'b0, sh_q[8:1]};
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                if (fall_edge) begin
                    if (ps2d == 1'b0) begin
                        ok_d = 1'b1;
                    end else begin
                        ok_d  = 1'b0;
                        err_d = 1'b1;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lvl_q && ps2d == 1'b1) begin
                    done_d  = ok_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A frame that already reported a NACK does not report a second error.
        if (timeout) begin
            state_d = S_IDLE;
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = !(state_q == S_WAIT && !ok_q);
        end

        idle_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            filt_q  <= '1;
            lvl_q   <= 1'b1;
            sh_q    <= '0;
            bcnt_q  <= '0;
            tmr_q   <= '0;
            ok_q    <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            lvl_q   <= lvl_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            tmr_q   <= tmr_d;
            ok_q    <= ok_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;

    localparam int RTS  = 20;
    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int LOWC = 10;
    localparam int HIGC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done_tick && tx_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b, input string tag);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = ~b;
        chk({tag, ":busy"}, 32'(tx_idle), 32'd0);
    endtask

    // Counts negedges with ps2c held low by the host; bounded.
    task automatic wait_rts(output int len);
        int n;
        len = 0;
        n   = 0;
        while (ps2c === 1'b0 && n < 1000) begin
            len++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse();
        dev_c_low = 1'b1;
        cyc(LOWC);
        dev_c_low = 1'b0;
        cyc(HIGC);
    endtask

    // Device side of one full frame; the device samples data while the clock is high.
    task automatic frame(input logic [7:0] b, input logic p, input bit ack, input bit inject,
                         input string tag);
        logic [10:0] got;
        logic [10:0] exp;
        int len, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b, tag);
        wait_rts(len);
        chk({tag, ":rts_len"}, 32'(len), 32'(RTS));
        cyc(HIGC);
        got[0] = ps2d;
        for (int i = 1; i <= 10; i++) begin
            pulse();
            got[i] = ps2d;
            if (inject && i == 3) begin
                din    = 8'hFF;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        end
        if (ack) dev_d_low = 1'b1;
        dev_c_low = 1'b1;
        cyc(LOWC);
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        cyc(HIGC);
        exp = {1'b1, p, b, 1'b0};
        chk({tag, ":bits"}, 32'(got), 32'(exp));
        chk({tag, ":done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        chk({tag, ":err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        chk({tag, ":idle"}, 32'(tx_idle), 32'd1);
        chk({tag, ":lines"}, 32'({ps2c, ps2d}), 32'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1);
    end

    initial begin
        int len, n, d0, e0;
        logic d_pre;

        cyc(3);
        chk("rst:idle", 32'(tx_idle), 32'd1);
        chk("rst:done", 32'(tx_done_tick), 32'd0);
        chk("rst:err", 32'(tx_err), 32'd0);
        chk("rst:lines", 32'({ps2c, ps2d}), 32'b11);
        reset = 1'b1;
        cyc(3);

        // 0xED has six ones -> parity 1
        frame(8'hED, 1'b1, 1'b1, 1'b0, "ed");
        // 0xF4 has five ones -> parity 0; a 0xFF write lands mid-frame and is ignored
        frame(8'hF4, 1'b0, 1'b1, 1'b1, "f4busy");
        cyc(30);
        chk("f4busy:late_done", 32'(tx_idle), 32'd1);
        // 0xAA has four ones -> parity 1; device withholds the ack
        frame(8'hAA, 1'b1, 1'b0, 1'b0, "nack");

        // Device stops after four clocks; abort lands FL+1 (filter) + TO clocks after the 4th low
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h55, "to");
        wait_rts(len);
        cyc(HIGC);
        pulse();
        pulse();
        pulse();
        dev_c_low = 1'b1;
        n = 0;
        d_pre = 1'bx;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == LOWC) dev_c_low = 1'b0;
            if (tx_err) break;
            d_pre = ps2d;
        end
        chk("to:latency", 32'(n), 32'(FL + 1 + TO));
        chk("to:d3_held", 32'(d_pre), 32'd0);
        chk("to:lines", 32'({ps2c, ps2d}), 32'b11);
        chk("to:idle", 32'(tx_idle), 32'd1);
        cyc(20);
        chk("to:err_once", 32'(err_cnt - e0), 32'd1);
        chk("to:no_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of DATA while the host is pulling ps2d low (d1 of 0x81)
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h81, "rst_mid");
        wait_rts(len);
        cyc(HIGC);
        pulse();
        pulse();
        chk("rst_mid:d_low", 32'(ps2d), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid:lines", 32'({ps2c, ps2d}), 32'b11);
        chk("rst_mid:idle", 32'(tx_idle), 32'd1);
        chk("rst_mid:pulses", 32'({tx_done_tick, tx_err}), 32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(10);
        chk("rst_mid:no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // 0x00 -> parity 1
        frame(8'h00, 1'b1, 1'b1, 1'b0, "zero");

        chk("never_both", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send-side companion of the ps2_rx keyboard receiver on the board.
- Sends one command byte (e.g. 0xED LED set, 0xF4 enable, 0xFF reset) to the keyboard over the shared ps2d/ps2c open-drain lines.
- Uses the standard request-to-send / device-clocked / acknowledge sequence.
- Drives `tx_idle` so the board top can gate ps2_rx while a transmission owns the bus.

Parameters:
- RTS_CYCLES, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz).
- FILTER_LEN, 8, length of the shift-register glitch filter on ps2c (2..16).
- TIMEOUT_CYCLES, 1000000, max clk cycles between device clock edges before abort (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_ps2  input  1  one-cycle strobe; starts a transmission of din; ignored unless tx_idle=1.
- din  input  8  command byte, captured on the accepted wr_ps2.
- ps2d  inout  1  PS/2 data, open drain: drives 0 or Z only.
- ps2c  inout  1  PS/2 clock, open drain: drives 0 or Z only.
- tx_idle  output  1  1 when in IDLE and both lines are released.
- tx_done_tick  output  1  one-cycle pulse when the device acknowledge is received.
- tx_err  output  1  one-cycle pulse on missing ack or timeout.

Behaviour:
- Reset (asynchronous, active-low):
  - Enter IDLE; both lines Z.
  - tx_idle=1, tx_done_tick=0, tx_err=0.
  - Shift register, bit counter, timers and filter cleared; filter is preset to all-ones (line high).
- Clock filter:
  - ps2c is sampled every clk into a FILTER_LEN shift register.
  - Filtered level goes to 1 when all samples are 1 and to 0 when all are 0; otherwise it holds.
  - fall_edge is a one-cycle pulse when the filtered level goes 1->0.
  - ps2d is sampled raw (it is stable while the clock is low).
- Frame: start bit 0; data bits d0..d7, LSB first; odd parity p = ~^din; stop 1; then device ack 0.
- State machine:
  - IDLE: lines Z. On wr_ps2, latch {p,din} into a 9-bit shift register, tx_idle->0, go to RTS next cycle.
  - RTS: ps2c=0, ps2d=Z for exactly RTS_CYCLES clks, then go to START.
  - START: ps2d=0 (start bit) and ps2c released (Z), both in the same cycle. Go to DATA with bit counter = 0.
  - DATA:
    - Keep driving ps2d from the shift-register LSB (0 -> drive 0, 1 -> Z).
    - On each fall_edge, shift right and increment the counter.
    - Edges 1..8 present d0..d7; edge 9 presents p.
    - On edge 10, release ps2d (stop bit) and go to ACK.
  - ACK: on the next fall_edge (11th), sample ps2d.
    - 0 -> go to WAIT_IDLE with success.
    - 1 -> pulse tx_err, go to WAIT_IDLE with failure.
  - WAIT_IDLE: lines Z. When filtered ps2c=1 and ps2d=1:
    - on success, pulse tx_done_tick;
    - in either case return to IDLE.
- Timeout:
  - Watchdog counts clks in START, DATA, ACK and WAIT_IDLE; it resets on every fall_edge.
  - Reaching TIMEOUT_CYCLES causes, in one cycle: release both lines, pulse tx_err, go to IDLE.
  - The watchdog is inactive in IDLE and RTS.
- Busy handling: wr_ps2 while tx_idle=0 is ignored; din changes after acceptance have no effect.
- Pulse rules:
  - tx_done_tick and tx_err never assert in the same cycle.
  - Each asserts at most once per accepted wr_ps2.
- tx_idle deasserts the cycle after wr_ps2 is accepted and reasserts the cycle IDLE is re-entered.
- Reset mid-frame: lines are released immediately (asynchronously) and no pulse is generated.
- Parity: a 0x00 byte has p=1; a byte with an even number of ones gets p=1.

Test Plan:
- RTS_CYCLES=20, FILTER_LEN=4, device model ACKs; wr_ps2 with din=0xED -> ps2c low for 20 clks; device samples start 0, then bits 1,0,1,1,0,1,1,1, p=1, stop 1; model ack 0 -> exactly one tx_done_tick, no tx_err, tx_idle returns to 1.
- din=0xF4 -> sampled bits 0,0,1,0,1,1,1,1, parity 0; tx_done_tick once.
- Device model holds ps2d=1 at the 11th falling edge -> tx_err one pulse, no tx_done_tick, lines released, tx_idle=1 after lines are high.
- TIMEOUT_CYCLES=200; model stops clocking after 4 falling edges -> tx_err exactly 200 clks after the last edge; ps2d/ps2c become Z the same cycle.
- Second wr_ps2 (din=0xFF) issued in DATA -> ignored; the frame on the bus still carries the first byte; only one completion pulse.
- Assert reset mid-DATA -> ps2d/ps2c Z asynchronously, all outputs at reset values; after release, a fresh wr_ps2 din=0x00 -> bits all 0, parity 1, tx_done_tick.
